// File: rtl/logic_shift_seq_32.sv
// -----------------------------------------------------------------------------
// logic_shift_seq_32
//
// Multi-cycle 32-bit logic/shift execution unit with a start/busy/done
// handshake. Bitwise operations (AND, OR, NOR, NOT A) take a single execute
// cycle. Logical shifts (SLL, SRL) move one bit position per clock, so a shift
// by n spends n+1 cycles in SHIFT. Every operation passes through FIN, whose
// exit edge raises the one-cycle done pulse.
//
// Latency from the accepting edge k to the edge that raises done:
//   logic op / unsupported op : k+2
//   shift by n (0..31)        : k+n+2
//
// Ports
//   clk     in   1       rising-edge clock
//   rst_n   in   1       asynchronous active-low reset
//   start   in   1       operation request, sampled only in IDLE
//   op      in   3       000 AND, 001 OR, 010 NOR, 011 NOT A,
//                        100 SLL, 101 SRL, 11x unsupported
//   a       in   WIDTH   operand A / shift source
//   b       in   WIDTH   operand B / shift amount in b[SHAMT_W-1:0]
//   result  out  WIDTH   registered result, held until the next op completes
//   zero    out  1       1 when result == 0 (decoded from the result register)
//   busy    out  1       1 while the operation is executing or shifting
//   done    out  1       registered single-cycle completion pulse
//   err     out  1       set together with done for an unsupported op,
//                        cleared when the next op is accepted
// -----------------------------------------------------------------------------
module logic_shift_seq_32 #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // ---------------------------------------------------------------------------
  // Opcode map
  // ---------------------------------------------------------------------------
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_NOR = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_SHIFT = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t               state;
  logic [2:0]           op_q;      // opcode latched at acceptance
  logic [WIDTH-1:0]     a_q;       // operand A latched at acceptance
  logic [WIDTH-1:0]     b_q;       // operand B latched at acceptance
  logic [WIDTH-1:0]     work_q;    // shift working register
  logic [SHAMT_W-1:0]   cnt_q;     // remaining shift positions

  logic                 start_is_shift;
  logic                 op_q_unsup;
  logic [WIDTH-1:0]     exec_value;

  // The incoming opcode decides which working state the accept edge enters.
  assign start_is_shift = (op == OP_SLL) || (op == OP_SRL);

  // Codes 110 and 111 are the only unsupported encodings.
  assign op_q_unsup = (op_q[2:1] == 2'b11);

  // ---------------------------------------------------------------------------
  // Bitwise result on the latched operands. Shift and unsupported codes fall
  // into the default arm and yield zero, which is exactly what an unsupported
  // op must write to result.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: a default assignment ahead of the case keeps every path driven,
    // so no latch is inferred for exec_value.
    exec_value = '0;
    case (op_q)
      OP_AND:  exec_value = a_q & b_q;
      OP_OR:   exec_value = a_q | b_q;
      OP_NOR:  exec_value = ~(a_q | b_q);
      OP_NOT:  exec_value = ~a_q;
      default: exec_value = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequencer. All outputs except zero are registered here so that busy,
  // done and err are glitch-free and line up with the state transitions.
  // ---------------------------------------------------------------------------
  // NOTE: every register here, including the operand latches and the shift
  // working register, is a plain flop rather than a memory, so all of them are
  // cleared by reset; an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      work_q <= '0;
      cnt_q  <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // the pre-edge values regardless of statement order.
      done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
            err  <= 1'b0;
            busy <= 1'b1;
            if (start_is_shift) begin
              // Only the low SHAMT_W bits of b form the amount; the upper
              // bits are ignored, so an amount of 33 behaves like 1.
              work_q <= a;
              cnt_q  <= b[SHAMT_W-1:0];
              state  <= S_SHIFT;
            end else begin
              state <= S_EXEC;
            end
          end
        end

        S_EXEC: begin
          result <= exec_value;
          busy   <= 1'b0;
          state  <= S_FIN;
        end

        S_SHIFT: begin
          if (cnt_q != '0) begin
            if (op_q == OP_SRL) begin
              work_q <= {1'b0, work_q[WIDTH-1:1]};
            end else begin
              work_q <= {work_q[WIDTH-2:0], 1'b0};
            end
            cnt_q <= cnt_q - SHAMT_W'(1);
          end else begin
            // Amount exhausted: this edge publishes the shifted value.
            result <= work_q;
            busy   <= 1'b0;
            state  <= S_FIN;
          end
        end

        S_FIN: begin
          // start is deliberately not looked at here; a request has to be
          // presented again once the unit is back in IDLE.
          done  <= 1'b1;
          err   <= op_q_unsup;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Zero flag decoded straight from the result register.
  assign zero = ~|result;

endmodule

// File: tb/tb_logic_shift_seq_32.sv
// -----------------------------------------------------------------------------
// tb_logic_shift_seq_32
//
// Self-checking bench for logic_shift_seq_32. Expected results, error flags
// and latencies come from a behavioural model that applies the operation
// directly with SystemVerilog operators and derives the latency from the
// shift amount. Inputs are driven 1 ns after the rising edge and outputs are
// sampled at the same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_logic_shift_seq_32;

  localparam int WIDTH   = 32;
  localparam int MAX_LAT = 40;   // bound on any wait for done

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;
  logic             done;
  logic             err;

  int n_checks;
  int n_fail;

  logic_shift_seq_32 #(.WIDTH(WIDTH), .SHAMT_W(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .result (result),
    .zero   (zero),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [WIDTH-1:0] model_result(input logic [2:0] mop,
                                                    input logic [WIDTH-1:0] ma,
                                                    input logic [WIDTH-1:0] mb);
    int sh;
    sh = int'(mb % 32);
    case (mop)
      3'd0:    return ma & mb;
      3'd1:    return ma | mb;
      3'd2:    return ~(ma | mb);
      3'd3:    return ~ma;
      3'd4:    return ma << sh;
      3'd5:    return ma >> sh;
      default: return '0;
    endcase
  endfunction

  function automatic int model_latency(input logic [2:0] mop,
                                       input logic [WIDTH-1:0] mb);
    if (mop == 3'd4 || mop == 3'd5) return int'(mb % 32) + 2;
    return 2;
  endfunction

  function automatic logic model_err(input logic [2:0] mop);
    return (mop == 3'd6) || (mop == 3'd7);
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: issues one op from IDLE, scrambles operands after acceptance and
  // counts edges until done. lat = -1 on timeout. busy_n counts the post-edge
  // samples (from the accepting edge onward, before done) with busy high.
  // ---------------------------------------------------------------------------
  task automatic run_op(input  logic [2:0]       t_op,
                        input  logic [WIDTH-1:0] t_a,
                        input  logic [WIDTH-1:0] t_b,
                        output int               lat,
                        output int               busy_n,
                        output logic [WIDTH-1:0] t_res,
                        output logic             t_err,
                        output logic             t_zero);
    start = 1'b1;
    op    = t_op;
    a     = t_a;
    b     = t_b;
    @(posedge clk);
    #1;
    start  = 1'b0;
    op     = 3'($urandom);
    a      = $urandom;
    b      = $urandom;
    lat    = -1;
    busy_n = busy ? 1 : 0;
    for (int i = 1; i <= MAX_LAT; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
      if (busy) busy_n++;
    end
    t_res  = result;
    t_err  = err;
    t_zero = zero;
  endtask

  // ---------------------------------------------------------------------------
  // Reset: values during reset, then reset in the middle of a long shift.
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int lat, bn, pulses;
    logic [WIDTH-1:0] r;
    logic e, z;

    n_checks++;
    if (result !== '0 || zero !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: result=%h zero=%b busy=%b done=%b err=%b, want 0/1/0/0/0",
               result, zero, busy, done, err);
    end

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Make result non-zero so the abort has something to clear.
    run_op(3'd1, 32'h1234_0000, 32'h0000_5678, lat, bn, r, e, z);
    n_checks++;
    if (r !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL reset_preload: result=%h, want 12345678", r);
    end

    start = 1'b1;
    op    = 3'd4;
    a     = 32'h0000_0001;
    b     = 32'd20;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_midshift_busy: busy=%b, want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || result !== '0 || zero !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abort: busy=%b result=%h zero=%b done=%b err=%b, want 0/0/1/0/0",
               busy, result, zero, done, err);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) pulses++;
    end
    n_checks++;
    if (pulses !== 0 || result !== '0) begin
      n_fail++;
      $display("FAIL reset_no_done: activity cycles=%0d result=%h, want 0 and 0", pulses, result);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Bitwise operations on the directed operand pair.
  // ---------------------------------------------------------------------------
  task automatic test_logic_ops();
    logic [WIDTH-1:0] want [4];
    int lat, bn;
    logic [WIDTH-1:0] r;
    logic e, z;
    want[0] = 32'hF000_F000;
    want[1] = 32'hFFF0_FFF0;
    want[2] = 32'h000F_000F;
    want[3] = 32'h0F0F_0F0F;
    for (int i = 0; i < 4; i++) begin
      run_op(3'(i), 32'hF0F0_F0F0, 32'hFF00_FF00, lat, bn, r, e, z);
      n_checks++;
      if (r !== want[i] || r !== model_result(3'(i), 32'hF0F0_F0F0, 32'hFF00_FF00)) begin
        n_fail++;
        $display("FAIL logic_op%0d_result: got %h, want %h", i, r, want[i]);
      end
      n_checks++;
      if (lat !== 2 || z !== 1'b0 || e !== 1'b0 || bn !== 1) begin
        n_fail++;
        $display("FAIL logic_op%0d_timing: lat=%0d zero=%b err=%b busy_cycles=%0d, want 2/0/0/1",
                 i, lat, z, e, bn);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Shift boundaries: maximum amount, zero amount, amount wrapping past 31.
  // ---------------------------------------------------------------------------
  task automatic test_shifts();
    logic [2:0]       s_op [3];
    logic [WIDTH-1:0] s_a  [3];
    logic [WIDTH-1:0] s_b  [3];
    logic [WIDTH-1:0] s_w  [3];
    int               s_l  [3];
    int lat, bn;
    logic [WIDTH-1:0] r;
    logic e, z;
    s_op[0] = 3'd4; s_a[0] = 32'h0000_0001; s_b[0] = 32'd31; s_w[0] = 32'h8000_0000; s_l[0] = 33;
    s_op[1] = 3'd5; s_a[1] = 32'h8000_0000; s_b[1] = 32'd0;  s_w[1] = 32'h8000_0000; s_l[1] = 2;
    s_op[2] = 3'd5; s_a[2] = 32'h8000_0000; s_b[2] = 32'd32; s_w[2] = 32'h8000_0000; s_l[2] = 2;
    for (int i = 0; i < 3; i++) begin
      run_op(s_op[i], s_a[i], s_b[i], lat, bn, r, e, z);
      n_checks++;
      if (r !== s_w[i] || lat !== s_l[i] || e !== 1'b0 || bn !== s_l[i] - 1) begin
        n_fail++;
        $display("FAIL shift%0d: result=%h lat=%0d err=%b busy_cycles=%0d, want %h/%0d/0/%0d",
                 i, r, lat, e, bn, s_w[i], s_l[i], s_l[i] - 1);
      end
    end
    // SLL by 33 acts as a shift by 1.
    run_op(3'd4, 32'h4000_0003, 32'd33, lat, bn, r, e, z);
    n_checks++;
    if (r !== 32'h8000_0006 || lat !== 3) begin
      n_fail++;
      $display("FAIL shift_amount33: result=%h lat=%0d, want 80000006/3", r, lat);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Zero flag and unsupported-op error handling.
  // ---------------------------------------------------------------------------
  task automatic test_zero_err();
    int lat, bn;
    logic [WIDTH-1:0] r;
    logic e, z;
    run_op(3'd0, 32'hAAAA_AAAA, 32'h5555_5555, lat, bn, r, e, z);
    n_checks++;
    if (r !== '0 || z !== 1'b1 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_flag: result=%h zero=%b err=%b, want 0/1/0", r, z, e);
    end
    run_op(3'd6, 32'hDEAD_BEEF, 32'h0000_0007, lat, bn, r, e, z);
    n_checks++;
    if (r !== '0 || e !== 1'b1 || lat !== 2 || z !== 1'b1) begin
      n_fail++;
      $display("FAIL err_op6: result=%h err=%b lat=%0d zero=%b, want 0/1/2/1", r, e, lat, z);
    end
    run_op(3'd1, 32'h0000_00F0, 32'h0000_000F, lat, bn, r, e, z);
    n_checks++;
    if (e !== 1'b0 || r !== 32'h0000_00FF || z !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: err=%b result=%h zero=%b, want 0/000000ff/0", e, r, z);
    end
    run_op(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bn, r, e, z);
    n_checks++;
    if (r !== '0 || e !== 1'b1 || lat !== 2) begin
      n_fail++;
      $display("FAIL err_op7: result=%h err=%b lat=%0d, want 0/1/2", r, e, lat);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Handshake: start held high through a shift, operands changed while busy,
  // second op accepted after exactly one idle cycle, no queued extra ops.
  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    int lat, extra;
    start = 1'b1;
    op    = 3'd4;
    a     = 32'h0000_00A5;
    b     = 32'd3;
    @(posedge clk);
    #1;
    // Operands for the op that the held start will launch next.
    a = 32'h1111_0001;
    b = 32'hFFFF_FFE1;   // amount 1
    lat = -1;
    for (int i = 1; i <= MAX_LAT; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    n_checks++;
    if (lat !== 5 || result !== model_result(3'd4, 32'h0000_00A5, 32'd3) || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_first: lat=%0d result=%h busy=%b, want 5/%h/0",
               lat, result, busy, model_result(3'd4, 32'h0000_00A5, 32'd3));
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL hs_one_idle: done=%b busy=%b, want 0/1", done, busy);
    end
    lat = -1;
    for (int i = 1; i <= MAX_LAT; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    n_checks++;
    if (lat !== 3 || result !== 32'h2222_0002) begin
      n_fail++;
      $display("FAIL hs_second: lat=%0d result=%h, want 3/22220002", lat, result);
    end
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (busy || done) extra++;
    end
    n_checks++;
    if (extra !== 0 || result !== 32'h2222_0002) begin
      n_fail++;
      $display("FAIL hs_no_queue: activity cycles=%0d result=%h, want 0/22220002", extra, result);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Random ops against the model.
  // ---------------------------------------------------------------------------
  task automatic test_random();
    int lat, bn;
    logic [WIDTH-1:0] r, ra, rb, w;
    logic [2:0] rop;
    logic e, z;
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(7, 0));
      ra  = $urandom;
      rb  = $urandom;
      if (($urandom % 4) == 0) rb[4:0] = 5'd0;
      w = model_result(rop, ra, rb);
      run_op(rop, ra, rb, lat, bn, r, e, z);
      n_checks++;
      if (r !== w || e !== model_err(rop) || z !== (w == '0) ||
          lat !== model_latency(rop, rb)) begin
        n_fail++;
        $display("FAIL rand%0d op=%0d a=%h b=%h: result=%h err=%b zero=%b lat=%0d, want %h/%b/%b/%0d",
                 i, rop, ra, rb, r, e, z, lat, w, model_err(rop), (w == '0),
                 model_latency(rop, rb));
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    op       = '0;
    a        = '0;
    b        = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_logic_ops();
    test_shifts();
    test_zero_err();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
